seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DIV, default 50000, meaning clk cycles per digit slot; legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock, all state on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port data, input, 16 bits: display value, driven directly by the memory controller's data_out (location 0x20).
REQ-005 The block SHALL have port an, output, 4 bits: digit anode enables, active-low; an[0] is the rightmost digit.
REQ-006 The block SHALL have port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-007 The block SHALL have port frame, output, 1 bit: one-cycle pulse when a new snapshot is taken.

Function
REQ-008 The block SHALL keep a prescaler counting 0..DIV-1 that wraps to 0; tick is asserted on the cycle the prescaler equals DIV-1.
REQ-009 The block SHALL keep a 2-bit digit index, incremented on tick, wrapping 3->0.
REQ-010 The block SHALL load a 16-bit snapshot register from data on a tick where the digit index is 3 (index moving to 0), and pulse frame high on that same edge; data changes mid-frame SHALL NOT affect the frame in progress.
REQ-011 The block SHALL select nibble snap[4*i+3:4*i] for digit index i.
REQ-012 The block SHALL register an and seg every cycle from the current digit index and snapshot: 1-cycle latency from index change to outputs.
REQ-013 The block SHALL drive exactly one an bit low (bit i = digit index) outside reset and blanking.
REQ-014 The block SHALL encode nibbles (hex seg): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-015 The block SHALL treat tick and snapshot load in the same cycle as one event: the snapshot loads, the index goes to 0, and the next registered outputs show digit 0 of the new snapshot.
REQ-016 The block SHALL produce a full frame every 4*DIV cycles, with each digit active exactly DIV cycles.

Reset
REQ-017 On rst_n low the block SHALL immediately force: prescaler=0, digit index=0, snapshot=0, frame=0, an=4'b1111, seg=7'h7F.
REQ-018 After rst_n rises, the first clk edge SHALL drive an=4'b1110, seg=7'h40 (digit 0 of snapshot 0).
REQ-019 The block SHALL abandon any in-progress frame on reset mid-operation; no partial state survives.
REQ-020 The first frame pulse after reset SHALL occur on the edge ending cycle 4*DIV-1 (counting the first edge after release as cycle 0).

Configuration
REQ-021 The block SHALL use the macro SEG_LEADING_ZERO_BLANK_EN.
REQ-022 With SEG_LEADING_ZERO_BLANK_EN defined, the block SHALL blank any digit i>0 whose nibble and all higher nibbles are zero, driving an=4'b1111 and seg=7'h7F during that digit's slot; digit 0 is never blanked.
REQ-023 With SEG_LEADING_ZERO_BLANK_EN undefined, the block SHALL display all four digits including leading zeros.
REQ-024 Slot timing, frame pulse and snapshot behaviour SHALL be identical in both builds.

Verification (DIV=4 unless noted)
REQ-025 Reset then data=16'h1A2F held -> per slot an/seg = 1110/0E, 1101/24, 1011/08, 0111/79; each lasts 4 cycles, then the sequence repeats.
REQ-026 data changes 16'h1234->16'h5678 during the digit-1 slot -> the current frame still shows 4,3,2,1; the next frame after the frame pulse shows 8,7,6,5.
REQ-027 rst_n low mid-frame at digit 2 -> an=1111 and seg=7F asynchronously; after release, scanning restarts at digit 0 with value 0.
REQ-028 data=16'h0005 with the macro defined -> digit 0 seg=12; digits 1-3 have an=1111 during their slots; without the macro, digits 1-3 show seg=40.
REQ-029 DIV=2, run 3 frames -> frame pulses exactly every 8 cycles; each an pattern is held 2 cycles.
REQ-030 data=16'h0000 with the macro defined -> only digit 0 lit, seg=40.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with per-frame snapshot of the display value.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN turns off leading-zero digits (digit 0 always lit).
module seg_scan_ctrl #(
  parameter int unsigned DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_t;

  logic [PW-1:0] r_presc;
  digit_t        r_idx;
  logic [15:0]   r_snap;

  logic          w_tick;
  logic [3:0]    w_nib;
  logic [3:0]    w_an_sel;
  logic          w_blank;
  logic [6:0]    w_seg_hex;

  assign w_tick = (r_presc == PW'(DIV - 1));

  always_comb begin
    w_nib    = r_snap[3:0];
    w_an_sel = 4'b1110;
    w_blank  = 1'b0;
    case (r_idx)
      DIG0: begin
        w_nib    = r_snap[3:0];
        w_an_sel = 4'b1110;
      end
      DIG1: begin
        w_nib    = r_snap[7:4];
        w_an_sel = 4'b1101;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        w_blank  = (r_snap[15:4] == 12'h000);
`endif
      end
      DIG2: begin
        w_nib    = r_snap[11:8];
        w_an_sel = 4'b1011;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        w_blank  = (r_snap[15:8] == 8'h00);
`endif
      end
      DIG3: begin
        w_nib    = r_snap[15:12];
        w_an_sel = 4'b0111;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        w_blank  = (r_snap[15:12] == 4'h0);
`endif
      end
      default: begin
        w_nib    = r_snap[3:0];
        w_an_sel = 4'b1110;
      end
    endcase
  end

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  always_comb begin
    w_seg_hex = 7'h7F;
    case (w_nib)
      4'h0: w_seg_hex = 7'h40;
      4'h1: w_seg_hex = 7'h79;
      4'h2: w_seg_hex = 7'h24;
      4'h3: w_seg_hex = 7'h30;
      4'h4: w_seg_hex = 7'h19;
      4'h5: w_seg_hex = 7'h12;
      4'h6: w_seg_hex = 7'h02;
      4'h7: w_seg_hex = 7'h78;
      4'h8: w_seg_hex = 7'h00;
      4'h9: w_seg_hex = 7'h10;
      4'hA: w_seg_hex = 7'h08;
      4'hB: w_seg_hex = 7'h03;
      4'hC: w_seg_hex = 7'h46;
      4'hD: w_seg_hex = 7'h21;
      4'hE: w_seg_hex = 7'h06;
      4'hF: w_seg_hex = 7'h0E;
      default: w_seg_hex = 7'h7F;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= DIG0;
      r_snap  <= '0;
      frame   <= 1'b0;
      an      <= '1;
      seg     <= '1;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      frame   <= 1'b0;
      if (w_tick) begin
        r_idx <= digit_t'(r_idx + 2'd1);
        // Snapshot and wrap to digit 0 happen on the same edge
        if (r_idx == DIG3) begin
          r_snap <= data;
          frame  <= 1'b1;
        end
      end
      an  <= w_blank ? 4'b1111 : w_an_sel;
      seg <= w_blank ? 7'h7F : w_seg_hex;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: DIV=4 main instance plus a DIV=2 timing instance.
module tb_seg_scan_ctrl;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] data;
  logic [3:0]  an1, an2;
  logic [6:0]  seg1, seg2;
  logic        frame1, frame2;

  seg_scan_ctrl #(.DIV(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .data(data), .an(an1), .seg(seg1), .frame(frame1)
  );

  seg_scan_ctrl #(.DIV(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .data(data), .an(an2), .seg(seg2), .frame(frame2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame;
  } exp_t;

  // segs packs expected seg per digit as {d3,d2,d1,d0}; mask marks digits blanked with the macro
  typedef struct {
    logic [15:0] data;
    logic [27:0] segs;
    logic [3:0]  mask;
  } row_t;

  row_t rows[8];
  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [27:0] ZERO_SEGS = {7'h40, 7'h40, 7'h40, 7'h40};

  task automatic push_frame(input int unsigned div, input logic [27:0] segs, input logic [3:0] mask);
    exp_t e;
    for (int unsigned k = 0; k < 4 * div; k++) begin
      int unsigned d;
      d = k / div;
      e.frame = (k == 4 * div - 1);
      if (BLANK && mask[d]) begin
        e.an  = 4'b1111;
        e.seg = 7'h7F;
      end else begin
        e.an  = ~(4'b0001 << d);
        e.seg = segs[7*d +: 7];
      end
      q.push_back(e);
    end
  endtask

  task automatic run_cycle(input bit sel, input string tag);
    exp_t act, e;
    @(posedge clk);
    #1;
    act = sel ? {an2, seg2, frame2} : {an1, seg1, frame1};
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard_empty an=%b seg=%h frame=%b", tag, act.an, act.seg, act.frame);
    end else begin
      e = q.pop_front();
      if (act !== e) begin
        bad++;
        $display("FAIL %s t=%0t an=%b seg=%h frame=%b expected an=%b seg=%h frame=%b",
                 tag, $time, act.an, act.seg, act.frame, e.an, e.seg, e.frame);
      end
    end
  endtask

  task automatic check_reset(input string tag);
    total++;
    if ({an1, seg1, frame1} !== {4'b1111, 7'h7F, 1'b0}) begin
      bad++;
      $display("FAIL %s div4 an=%b seg=%h frame=%b expected an=1111 seg=7f frame=0", tag, an1, seg1, frame1);
    end
    total++;
    if ({an2, seg2, frame2} !== {4'b1111, 7'h7F, 1'b0}) begin
      bad++;
      $display("FAIL %s div2 an=%b seg=%h frame=%b expected an=1111 seg=7f frame=0", tag, an2, seg2, frame2);
    end
  endtask

  initial begin
    rows[0] = '{16'h1A2F, {7'h79, 7'h08, 7'h24, 7'h0E}, 4'b0000};
    rows[1] = '{16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0000};
    rows[2] = '{16'h5678, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b0000};
    rows[3] = '{16'h9BCD, {7'h10, 7'h03, 7'h46, 7'h21}, 4'b0000};
    rows[4] = '{16'h0E00, {7'h40, 7'h06, 7'h40, 7'h40}, 4'b1000};
    rows[5] = '{16'h0005, {7'h40, 7'h40, 7'h40, 7'h12}, 4'b1110};
    rows[6] = '{16'h0000, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1110};
    rows[7] = '{16'h00C0, {7'h40, 7'h40, 7'h46, 7'h40}, 4'b1100};

    data  = 16'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset("reset_hold");

    @(negedge clk) rst_n = 1'b1;
    push_frame(4, ZERO_SEGS, 4'b1110);

    // data switches during each frame's digit-1 slot; the next frame must show it
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < 16; k++) begin
        run_cycle(1'b0, "scan");
        if (k == 4) begin
          data = rows[j].data;
          push_frame(4, rows[j].segs, rows[j].mask);
        end
      end
    end
    for (int k = 0; k < 16; k++) begin
      run_cycle(1'b0, "scan_tail");
      if (k == 4) push_frame(4, rows[7].segs, rows[7].mask);
    end
    for (int k = 0; k < 9; k++) run_cycle(1'b0, "pre_reset");

    #1 rst_n = 1'b0;
    #1 check_reset("async_reset");
    q.delete();
    @(posedge clk);
    #1 check_reset("reset_clocked");

    @(negedge clk) rst_n = 1'b1;
    push_frame(4, ZERO_SEGS, 4'b1110);
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 16; k++) begin
        run_cycle(1'b0, "post_reset");
        if (k == 4) push_frame(4, rows[7].segs, rows[7].mask);
      end
    end
    q.delete();

    data  = 16'h1111;
    rst_n = 1'b0;
    #1 check_reset("div2_reset");
    @(negedge clk) rst_n = 1'b1;
    push_frame(2, ZERO_SEGS, 4'b1110);
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 8; k++) begin
        run_cycle(1'b1, "div2");
        if (k == 2) push_frame(2, {7'h79, 7'h79, 7'h79, 7'h79}, 4'b0000);
      end
    end
    q.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
